// File: rtl/shift_arb_if.sv
// Handshake/serial bundle between two word producers, the arbiter and the serial link.
interface shift_arb_if #(
    parameter int W = 8
);
    logic         req0;
    logic [W-1:0] data0;
    logic         req1;
    logic [W-1:0] data1;
    logic         gnt0;
    logic         gnt1;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_last;
    logic         busy;
    logic         owner;
    logic         done;

    modport master (
        output req0, data0, req1, data1,
        input  gnt0, gnt1, ser_out, ser_valid, ser_last, busy, owner, done
    );

    modport slave (
        input  req0, data0, req1, data1,
        output gnt0, gnt1, ser_out, ser_valid, ser_last, busy, owner, done
    );
endinterface

// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter sharing one W-bit LSB-first serializer between two requesters.
// Optional trailing even-parity bit when SHIFT_ARB_PARITY_EN is defined.
module shift_arb_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    shift_arb_if.slave   bus
);
    localparam int CW = $clog2(W + 1);

`ifdef SHIFT_ARB_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
    logic r_par;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t        r_state;
    logic [W-1:0]  r_shreg;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic          r_owner;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_ser_valid;
    logic          r_ser_last;
    logic          r_busy;
    logic          r_done;

    logic          w_win_vld;
    logic          w_win;
    logic [W-1:0]  w_win_data;

    // On a tie the requester that did not own the previous frame wins.
    always_comb begin
        w_win_vld  = bus.req0 | bus.req1;
        w_win      = 1'b0;
        if (bus.req0 && bus.req1) w_win = ~r_last;
        else                      w_win = bus.req1;
        w_win_data = w_win ? bus.data1 : bus.data0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef SHIFT_ARB_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_win_vld) begin
                        r_shreg     <= w_win_data;
                        r_owner     <= w_win;
                        r_cnt       <= '0;
                        r_gnt0      <= ~w_win;
                        r_gnt1      <= w_win;
                        r_ser_valid <= 1'b1;
                        r_ser_last  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= SHIFT;
`ifdef SHIFT_ARB_PARITY_EN
                        r_par       <= ^w_win_data;
`endif
                    end
                end
                SHIFT: begin
                    r_shreg <= {1'b0, r_shreg[W-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(W - 1)) begin
`ifdef SHIFT_ARB_PARITY_EN
                        // Parity rides out of shreg[0] so ser_out stays a plain register bit.
                        r_shreg    <= W'(r_par);
                        r_ser_last <= 1'b1;
                        r_state    <= PAR;
`else
                        r_ser_valid <= 1'b0;
                        r_ser_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
`endif
                    end else begin
`ifdef SHIFT_ARB_PARITY_EN
                        r_ser_last <= 1'b0;
`else
                        r_ser_last <= (r_cnt == CW'(W - 2));
`endif
                    end
                end
`ifdef SHIFT_ARB_PARITY_EN
                PAR: begin
                    r_shreg     <= '0;
                    r_ser_valid <= 1'b0;
                    r_ser_last  <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= DONE;
                end
`endif
                DONE: begin
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // shreg is all-zero outside a frame, so ser_out is 0 whenever ser_valid is low.
    assign bus.ser_out   = r_shreg[0];
    assign bus.ser_valid = r_ser_valid;
    assign bus.ser_last  = r_ser_last;
    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.busy      = r_busy;
    assign bus.owner     = r_owner;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Scoreboard bench for shift_arb_ctrl: expected frames queued at stimulus, checked at done.
module tb_shift_arb_ctrl;
    localparam int W = 8;
`ifdef SHIFT_ARB_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_arb_if #(.W(W)) bus ();
    shift_arb_ctrl #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic       owner;
        logic [W:0] word;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] frame_of(input logic [W-1:0] d);
`ifdef SHIFT_ARB_PARITY_EN
        return {^d, d};
`else
        return {1'b0, d};
`endif
    endfunction

    task automatic push(input logic o, input logic [W-1:0] d);
        exp_t e;
        e.owner = o;
        e.word  = frame_of(d);
        sb.push_back(e);
    endtask

    // Monitor: collect serial bits, check framing, compare against scoreboard at done.
    int         m_cnt = 0;
    logic [W:0] m_word = '0;
    logic       m_prev_last = 1'b0;
    logic       m_pl;
    int         m_done_cyc = 0;
    bit         m_have_done = 1'b0;
    bit         chk_gap = 1'b0;
    exp_t       m_e;

    always @(negedge clk) begin
        cyc++;
        m_pl = m_prev_last;
        if (bus.gnt0 | bus.gnt1) begin
            chk("gnt_first_bit", m_cnt, 0);
            chk("gnt_valid", bus.ser_valid, 1);
            chk("gnt_owner", bus.owner, bus.gnt1);
            chk("gnt_onehot", bus.gnt0 & bus.gnt1, 0);
            if (chk_gap && m_have_done) chk("gap", cyc - m_done_cyc, 2);
        end
        if (bus.ser_valid) begin
            chk("busy", bus.busy, 1);
            chk("ser_last", bus.ser_last, (m_cnt + 1 == NB));
            if (m_cnt <= W) m_word[m_cnt] = bus.ser_out;
            m_cnt++;
        end else begin
            chk("idle_out", {bus.ser_out, bus.ser_last}, 0);
        end
        if (bus.done) begin
            chk("done_bits", m_cnt, NB);
            chk("done_after_last", m_pl, 1);
            chk("done_busy", bus.busy, 1);
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                m_e = sb.pop_front();
                chk("owner", bus.owner, m_e.owner);
                chk("word", m_word, m_e.word);
            end
            m_cnt       = 0;
            m_word      = '0;
            m_done_cyc  = cyc;
            m_have_done = 1'b1;
        end
        m_prev_last = bus.ser_valid & bus.ser_last;
    end

    task automatic clr_mon();
        m_cnt       = 0;
        m_word      = '0;
        m_prev_last = 1'b0;
        m_have_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr_mon();
    endtask

    // Requester model: raise req, wait for its gnt, optionally re-raise for the next word.
    task automatic requester(input bit idx, input logic [W-1:0] w, input int n);
        bit got;
        for (int f = 0; f < n; f++) begin
            if (idx) begin bus.req1 = 1'b1; bus.data1 = w; end
            else     begin bus.req0 = 1'b1; bus.data0 = w; end
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                got = idx ? bus.gnt1 : bus.gnt0;
            end
            if (!got) chk("gnt_timeout", 0, 1);
        end
        if (idx) bus.req1 = 1'b0;
        else     bus.req0 = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while ((sb.size() != 0 || bus.busy) && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("drain_timeout", (c < 300), 1);
        @(negedge clk);
    endtask

    initial begin
        bit got;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;

        // Reset then quiet: every output low, owner 0.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            chk("t1_outs", {bus.gnt0, bus.gnt1, bus.ser_out, bus.ser_valid,
                            bus.ser_last, bus.busy, bus.owner, bus.done}, 0);
        end

        // Single requester.
        push(1'b0, 8'hA5);
        requester(1'b0, 8'hA5, 1);
        drain();

        // Both requesting from reset: 0, 1, 0 with one idle cycle between frames.
        do_reset();
        chk_gap = 1'b1;
        push(1'b0, 8'hF0);
        push(1'b1, 8'h0F);
        push(1'b0, 8'hF0);
        fork
            requester(1'b0, 8'hF0, 2);
            requester(1'b1, 8'h0F, 1);
        join
        drain();

        // Requester 1 held high: back-to-back frames.
        m_have_done = 1'b0;
        push(1'b1, 8'h81);
        push(1'b1, 8'h81);
        push(1'b1, 8'h81);
        requester(1'b1, 8'h81, 3);
        drain();
        chk_gap = 1'b0;

        // Reset during the 4th bit: abort, then req0 re-accepted.
        push(1'b0, 8'hFF);
        bus.req0  = 1'b1;
        bus.data0 = 8'hFF;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            got = bus.gnt0;
        end
        if (!got) chk("t5_gnt_timeout", 0, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_abort", {bus.ser_valid, bus.busy, bus.done, bus.gnt0}, 0);
        clr_mon();
        rst = 1'b0;
        requester(1'b0, 8'hFF, 1);
        drain();

        // Parity-sensitive words (odd and even popcount).
        push(1'b0, 8'h07);
        requester(1'b0, 8'h07, 1);
        drain();
        push(1'b0, 8'h03);
        requester(1'b0, 8'h03, 1);
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_arb_ctrl.md
Name: shift_arb_ctrl

Overview:
- Controller that shares one W-bit right-shift serializer between two requesters, using round-robin arbitration.
- Per frame: grants one requester, loads its parallel word, then sequences W right-shifts LSB-first onto a serial output, then signals completion.
- Sits between two word producers and a single serial link. It replaces the free-running ld/sh control of the standalone shift register with a sequenced frame protocol.

Parameters:
W, 8, data word width in bits; legal range W >= 2.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req0  input  1  requester 0 has a word pending; held until gnt0
data0  input  W  requester 0 word; must be stable while req0 high
req1  input  1  requester 1 has a word pending; held until gnt1
data1  input  W  requester 1 word; must be stable while req1 high
gnt0  output  1  one-cycle pulse: data0 captured
gnt1  output  1  one-cycle pulse: data1 captured
ser_out  output  1  serial bit, LSB first; 0 when ser_valid low
ser_valid  output  1  ser_out carries a frame bit this cycle
ser_last  output  1  high with the final bit of a frame
busy  output  1  high from capture until done cycle inclusive
owner  output  1  index of current frame's requester; holds last value when idle
done  output  1  one-cycle pulse after final bit

Behaviour:
- Reset (rst=1 at an edge): state IDLE; all outputs 0; owner=0; shift register and bit counter cleared; round-robin pointer last=1, so requester 0 wins the first tie.
- States: IDLE, SHIFT, DONE (plus PAR when the optional feature is compiled in).
- IDLE, arbitration:
  - No request: remain in IDLE.
  - Exactly one request: that requester wins.
  - Both requests: the requester != last wins.
- IDLE, on the accept edge (call it edge k):
  - shreg <= winning data; owner <= winner; counter <= 0; state -> SHIFT.
  - The matching gnt is registered high for cycle k+1 only.
- SHIFT, cycles k+1 .. k+W:
  - ser_valid=1, ser_out=shreg[0], busy=1.
  - Each edge: shreg <= {1'b0, shreg[W-1:1]}; counter increments.
  - ser_last=1 during cycle k+W.
  - Exit to DONE (or PAR) after W bits.
  - req0/req1 are ignored while busy.
- DONE, cycle k+W+1:
  - done=1, busy=1, ser_valid=0.
  - last <= owner; state -> IDLE.
- Frame timing:
  - Latency from accept edge to first bit: 1 cycle.
  - Frame occupancy: W+1 cycles, after which the controller is back in IDLE.
  - The earliest next accept is at the end of cycle k+W+2, leaving one IDLE cycle between back-to-back frames.
- Requester protocol:
  - A requester deasserts req in response to gnt.
  - A req still high in IDLE after the frame is treated as a new request.
- Reset mid-frame: the frame is aborted. No done, no further ser_valid, pointer restored to last=1, and a pending req is re-arbitrated from IDLE.
- Counter width: $clog2(W+1); it never wraps within a frame.

Optional Feature:
Macro: SHIFT_ARB_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the captured word) is latched at capture.
  - After the W data bits, a PAR state emits it for one cycle with ser_valid=1 and ser_last=1. ser_last is not asserted on data bit W.
  - DONE follows PAR, so the frame is W+2 cycles.
- Undefined: no PAR state and no parity register; timing is exactly as above.

Test Plan:
1. rst=1 for 2 cycles, then 0, with no req -> all outputs 0, owner=0, busy=0 throughout.
2. req0=1, data0=8'hA5 -> gnt0 pulse the next cycle; ser_out 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles; ser_last on the 8th; done on the following cycle; owner=0.
3. req0 and req1 both asserted after reset (data0=8'hF0, data1=8'h0F, each requester re-raising req after its gnt) -> frames served in order: requester 0 (bits 0,0,0,0,1,1,1,1), then requester 1, then requester 0, with one idle cycle between frames.
4. req1 held high continuously with data1=8'h81 -> back-to-back frames separated by exactly one IDLE cycle; gnt1 pulses once per frame.
5. rst asserted during the 4th bit of a data0=8'hFF frame -> ser_valid, busy and done all 0 from the next cycle; no done pulse; req0 re-accepted after rst deasserts.
6. SHIFT_ARB_PARITY_EN defined: data0=8'h07 -> 9th bit 1 with ser_last; data0=8'h03 -> 9th bit 0; done one cycle later.
